// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/rotate/load commands plus an
// LSB-first serialising burst mode with busy/done handshake.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'b000,
    CMD_SHL   = 3'b001,
    CMD_SHR   = 3'b010,
    CMD_ROL   = 3'b011,
    CMD_ROR   = 3'b100,
    CMD_LOAD  = 3'b101,
    CMD_BURST = 3'b110,
    CMD_RSVD  = 3'b111
  } cmd_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0] q_next;
  logic            busy_next, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      cnt   <= cnt_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    q_next     = q;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (en) begin
          case (mode)
            CMD_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            CMD_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            CMD_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            CMD_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            CMD_LOAD: q_next = d;
            CMD_BURST: begin
              q_next     = d;
              cnt_next   = CW'(WIDTH - 1);
              state_next = BURST;
            end
            default:  q_next = q;
          endcase
        end
      end
      BURST: begin
        q_next = {sin_l, q[WIDTH-1:1]};
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // busy drops one cycle before the final shift so it spans exactly WIDTH-1
  // cycles; the last serial bit is still presented while busy is low.
  always_comb begin
    busy_next = (state_next == BURST) && (cnt_next != '0);
    done_next = (state == BURST) && (state_next == IDLE);
    sout_msb  = q[WIDTH-1];
    sout_lsb  = q[0];
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8): vector table plus
// hand-written burst sequences, checked through an expected-result queue.
module tb_universal_shift_reg;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] q;
  logic         sout_msb;
  logic         sout_lsb;
  logic         busy;
  logic         done;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_msb(sout_msb),
    .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   busy_cycles;
  int   done_pulses;

  task automatic check1(input string name, input string field,
                        input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s %s got %h want %h", name, field, got, want);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic sl, input logic sr,
                      input logic [W-1:0] eq, input logic eb, input logic ed,
                      input string name);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    x.q = eq; x.busy = eb; x.done = ed; x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check1(x.name, "q", q, x.q);
    check1(x.name, "busy", {7'b0, busy}, {7'b0, x.busy});
    check1(x.name, "done", {7'b0, done}, {7'b0, x.done});
    check1(x.name, "sout_lsb", {7'b0, sout_lsb}, {7'b0, x.q[0]});
    check1(x.name, "sout_msb", {7'b0, sout_msb}, {7'b0, x.q[W-1]});
    if (busy) busy_cycles++;
    if (done) done_pulses++;
  endtask

  // Load word dd as a burst, then WIDTH shift edges while distractor
  // commands (load of FF) are driven; the last edge must pulse done.
  task automatic burst(input logic [W-1:0] dd, input logic sl, input string name);
    logic [W-1:0] fill;
    logic [W-1:0] eq;
    busy_cycles = 0;
    done_pulses = 0;
    step(1'b0, 1'b1, 3'b110, dd, sl, 1'b0, dd, 1'b1, 1'b0, name);
    for (int k = 1; k <= int'(W); k++) begin
      fill = sl ? ~(8'hFF >> k) : 8'h00;
      eq   = (dd >> k) | fill;
      step(1'b0, 1'b1, 3'b101, 8'hFF, sl, 1'b1, eq,
           (k < int'(W) - 1), (k == int'(W)), name);
    end
    check1(name, "busy_cycles", 8'(busy_cycles), 8'(W - 1));
    check1(name, "done_pulses", 8'(done_pulses), 8'd1);
  endtask

  vec_t vt[$];

  initial begin
    logic [W-1:0] stream;
    logic [W-1:0] want_bits;
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = '0; sin_l = 1'b0; sin_r = 1'b0;

    //        rst   en    mode    d      sl    sr    q      busy  done
    vt.push_back('{1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'b101, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'b110, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b101, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h2D, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b101, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 3'b101, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'b101, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0});

    foreach (vt[i])
      step(vt[i].rst, vt[i].en, vt[i].mode, vt[i].d, vt[i].sin_l, vt[i].sin_r,
           vt[i].q, vt[i].busy, vt[i].done, $sformatf("vec%0d", i));

    // Serial stream of B4, captured independently of the per-step checks.
    want_bits = 8'b1011_0100;
    stream = '0;
    fork
      begin
        @(negedge clk);
        for (int k = 0; k < int'(W); k++) begin
          @(posedge clk);
          #2;
          stream[k] = sout_lsb;
        end
      end
      burst(8'hB4, 1'b0, "burst_b4");
    join
    check1("burst_b4", "stream", stream, want_bits);

    // Back-to-back: the next load is driven on the done cycle.
    burst(8'h01, 1'b1, "burst_b2b");

    // Reset on the third cycle of a burst aborts without done.
    busy_cycles = 0;
    done_pulses = 0;
    step(1'b0, 1'b1, 3'b110, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, "abort");
    step(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h2D, 1'b1, 1'b0, "abort");
    step(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h16, 1'b1, 1'b0, "abort");
    step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "abort_rst");
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b0, 3'b000, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, "abort_after");
    check1("abort", "done_pulses", 8'(done_pulses), 8'd0);

    // After abort the block accepts commands normally.
    step(1'b0, 1'b1, 3'b101, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, "post_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have the following ports, with clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  cycle enable; when 0, the command on mode is ignored.
- mode  input  3  command select, see REQ-005.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input into the MSB on right shifts.
- sin_r  input  1  serial input into the LSB on left shifts.
- q  output  WIDTH  registered contents.
- sout_msb  output  1  equals q[WIDTH-1], combinational from q.
- sout_lsb  output  1  equals q[0], combinational from q.
- busy  output  1  registered; high while a burst is in progress.
- done  output  1  registered; one-cycle pulse when a burst completes.

Function
REQ-003 The block SHALL have two states, IDLE and BURST, plus a shift counter cnt of ceil(log2(WIDTH+1)) bits.
REQ-004 In IDLE with en=0, q, cnt and state SHALL hold.
REQ-005 In IDLE with en=1, the block SHALL apply mode at the next rising edge:
- 000: hold.
- 001: shift left, q <= {q[WIDTH-2:0], sin_r}.
- 010: shift right, q <= {sin_l, q[WIDTH-1:1]}.
- 011: rotate left, q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 100: rotate right, q <= {q[0], q[WIDTH-1:1]}.
- 101: parallel load, q <= d.
- 110: burst start, q <= d, cnt <= WIDTH-1, state <= BURST, busy <= 1.
- 111: reserved, behaves as hold.
REQ-006 Every operation SHALL have single-cycle latency: the result is visible on q in the cycle after the edge that samples the command.
REQ-007 In BURST, each rising edge SHALL shift right with sin_l into the MSB, and decrement cnt.
REQ-008 In BURST, en and mode SHALL be ignored.
REQ-009 A burst SHALL serialise the loaded word LSB-first on sout_lsb:
- the load cycle presents bit 0;
- each following cycle presents the next bit;
- all WIDTH bits are presented on WIDTH consecutive cycles.
REQ-010 The block SHALL end a burst at the edge where cnt=0 in BURST:
- the block performs the final shift;
- state <= IDLE, busy <= 0, done <= 1 for exactly one cycle.
REQ-011 busy SHALL be high for exactly WIDTH-1 cycles per burst, starting the cycle after the load edge.
REQ-012 The cycle after a burst ends, the block SHALL be in IDLE, so a new command, including another burst, is accepted on that edge with no dead cycle.
REQ-013 done SHALL be 0 in every cycle other than the completion pulse.
REQ-014 sout_msb and sout_lsb SHALL have no added latency relative to q.

Reset
REQ-015 When rst=1 at a rising edge, the block SHALL set q <= 0, cnt <= 0, state <= IDLE, busy <= 0 and done <= 0, regardless of en, mode or state.
REQ-016 Reset SHALL take priority over all commands, including an in-progress burst; an aborted burst SHALL NOT produce done.
REQ-017 The first command accepted after reset deasserts SHALL be the one sampled on the first edge with rst=0.

Verification
REQ-018 The bench SHALL cover these scenarios with WIDTH=8:
- rst=1 for 2 cycles, then rst=0, en=0 -> q=8'h00, busy=0, done=0, held.
- mode=101, d=8'hA5, then mode=011 for 3 cycles -> q=8'hA5, 8'h4B, 8'h96, 8'h2D.
- q=8'h81, mode=010 with sin_l=1, then mode=001 with sin_r=0 -> q=8'hC0, then 8'h80.
- mode=110, d=8'hB4, sin_l=0 -> sout_lsb=0,0,1,0,1,1,0,1 on 8 consecutive cycles; busy high for 7 cycles; done pulses once; q=8'h00 after.
- During a burst, drive mode=101, d=8'hFF -> ignored; the serial stream is unchanged.
- rst=1 on the third cycle of a burst -> next cycle q=0, busy=0; no done pulse.
- Burst completes with mode=110, d=8'h01 applied on the done cycle -> new burst starts immediately; busy rises the next cycle.
